// File: rtl/pdp11_control.sv
// PDP-11 control unit: its own cycle counter (TC, falling-edge) plus combinational decode
// of the instruction register into datapath strobes for a 4-cycle micro-sequence.
module pdp11_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cmd,
    output logic [2:0]  cycle,
    output logic        reg_from_mem,
    output logic [2:0]  reg_src,
    output logic [2:0]  reg_dst,
    output logic        reg_we,
    output logic [2:0]  mem_addr,
    output logic        mem_byte,
    output logic        x_we,
    output logic        y_we,
    output logic        z_we,
    output logic [1:0]  alu_input,
    output logic [9:0]  alu_op,
    output logic        psw_we,
    output logic        mem_we,
    output logic        ir_we
);

    typedef enum logic [2:0] {
        T_FETCH = 3'd0,
        T_SRC   = 3'd1,
        T_DST   = 3'd2,
        T_EXEC  = 3'd3,
        T_HALT  = 3'd7
    } tc_t;

    typedef enum logic [3:0] {
        ALU_MOV = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_CMP = 4'd3,
        ALU_BIT = 4'd4,  ALU_BIC = 4'd5,  ALU_BIS = 4'd6,  ALU_CLR = 4'd7,
        ALU_INC = 4'd8,  ALU_DEC = 4'd9,  ALU_COM = 4'd10, ALU_NEG = 4'd11,
        ALU_TST = 4'd12, ALU_INC2 = 4'd13
    } alu_t;

    tc_t  tc, tc_next;
    alu_t op;
    logic op_ok, op_writes;

    wire [2:0] src_mode = cmd[11:9];
    wire [2:0] src_reg  = cmd[8:6];
    wire [2:0] dst_mode = cmd[5:3];
    wire [2:0] dst_reg  = cmd[2:0];

    wire is_halt   = (cmd == 16'd0);
    wire is_single = (cmd[14:9] == 6'b000101);
    wire is_sub    = (cmd[14:12] == 3'd6) && cmd[15];
    // SUB occupies the byte-flag slot of ADD, so it is always a word operation.
    wire byte_op   = cmd[15] && !is_sub;

    // NOTE: TC and all outputs use non-blocking assignment only in the clocked block;
    // the combinational blocks use blocking assignments so values settle in one pass.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) tc <= T_FETCH;
        else       tc <= tc_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        op        = ALU_MOV;
        op_ok     = 1'b1;
        op_writes = 1'b1;
        if (is_single) begin
            case (cmd[8:6])
                3'd0:    op = ALU_CLR;
                3'd1:    op = ALU_COM;
                3'd2:    op = ALU_INC;
                3'd3:    op = ALU_DEC;
                3'd4:    op = ALU_NEG;
                3'd7:    begin op = ALU_TST; op_writes = 1'b0; end
                default: op_ok = 1'b0;
            endcase
        end else begin
            case (cmd[14:12])
                3'd1:    op = ALU_MOV;
                3'd2:    begin op = ALU_CMP; op_writes = 1'b0; end
                3'd3:    begin op = ALU_BIT; op_writes = 1'b0; end
                3'd4:    op = ALU_BIC;
                3'd5:    op = ALU_BIS;
                3'd6:    op = cmd[15] ? ALU_SUB : ALU_ADD;
                default: op_ok = 1'b0;
            endcase
        end
    end

    wire supported = op_ok && (dst_mode <= 3'd1) && (is_single || src_mode <= 3'd1);
    wire src_ind   = !is_single && (src_mode == 3'd1);
    wire dst_ind   = (dst_mode == 3'd1);

    always_comb begin
        tc_next      = T_FETCH;
        reg_from_mem = 1'b0;
        reg_src      = 3'd0;
        reg_dst      = 3'd0;
        reg_we       = 1'b0;
        mem_addr     = 3'd0;
        mem_byte     = 1'b0;
        x_we         = 1'b0;
        y_we         = 1'b0;
        z_we         = 1'b0;
        alu_input    = 2'b00;
        alu_op       = 10'd0;
        psw_we       = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;

        case (tc)
            T_FETCH: begin
                reg_src = 3'd7;
                ir_we   = 1'b1;
                reg_dst = 3'd7;
                alu_op  = {6'd0, ALU_INC2};
                reg_we  = 1'b1;
                tc_next = T_SRC;
            end
            T_SRC: begin
                if (is_halt) begin
                    tc_next = T_HALT;
                end else if (supported) begin
                    if (src_ind) begin
                        reg_src  = src_reg;
                        x_we     = 1'b1;
                        mem_byte = byte_op;
                    end
                    tc_next = T_DST;
                end
            end
            T_DST: begin
                if (dst_ind) begin
                    reg_dst  = dst_reg;
                    mem_addr = 3'd2;
                    y_we     = 1'b1;
                    z_we     = 1'b1;
                    mem_byte = byte_op;
                end
                tc_next = T_EXEC;
            end
            T_EXEC: begin
                reg_src   = src_reg;
                reg_dst   = dst_reg;
                alu_input = {dst_ind, src_ind};
                alu_op    = {byte_op, 5'd0, op};
                psw_we    = 1'b1;
                if (op_writes) begin
                    if (dst_ind) begin
                        mem_addr = 3'd6;
                        mem_we   = 1'b1;
                        mem_byte = byte_op;
                    end else begin
                        reg_we = 1'b1;
                    end
                end
            end
            T_HALT:  tc_next = T_HALT;
            default: tc_next = T_FETCH;
        endcase

        if (reset) begin
            reg_we = 1'b0;
            x_we   = 1'b0;
            y_we   = 1'b0;
            z_we   = 1'b0;
            psw_we = 1'b0;
            mem_we = 1'b0;
            ir_we  = 1'b0;
        end
    end

    assign cycle = tc;

endmodule

// File: tb/tb_pdp11_control.sv
// Table-driven bench for pdp11_control: per-cycle expected output vectors for a set of
// instructions, plus hand sequences for reset mid-instruction and HALT.
module tb_pdp11_control;

    logic        clk, reset;
    logic [15:0] cmd;
    logic [2:0]  cycle, reg_src, reg_dst, mem_addr;
    logic        reg_from_mem, reg_we, mem_byte, x_we, y_we, z_we, psw_we, mem_we, ir_we;
    logic [1:0]  alu_input;
    logic [9:0]  alu_op;

    typedef struct packed {
        logic [2:0] cyc;
        logic       rfm;
        logic [2:0] src;
        logic [2:0] dst;
        logic       rwe;
        logic [2:0] maddr;
        logic       mbyte;
        logic       xwe, ywe, zwe;
        logic [1:0] ain;
        logic [9:0] op;
        logic       psw, mwe, irwe;
    } out_t;

    typedef struct {
        logic [15:0] cmd;
        out_t        exp;
    } vec_t;

    out_t act;
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    pdp11_control dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cycle(cycle), .reg_from_mem(reg_from_mem),
        .reg_src(reg_src), .reg_dst(reg_dst), .reg_we(reg_we), .mem_addr(mem_addr),
        .mem_byte(mem_byte), .x_we(x_we), .y_we(y_we), .z_we(z_we), .alu_input(alu_input),
        .alu_op(alu_op), .psw_we(psw_we), .mem_we(mem_we), .ir_we(ir_we)
    );

    assign act = {cycle, reg_from_mem, reg_src, reg_dst, reg_we, mem_addr, mem_byte,
                  x_we, y_we, z_we, alu_input, alu_op, psw_we, mem_we, ir_we};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(int cyc, int src, int dst, bit rwe, int maddr, bit mb,
                                bit x, bit y, bit z, int ain, int op, bit psw, bit mwe,
                                bit irwe);
        out_t o;
        o.cyc = cyc[2:0];   o.rfm = 1'b0;       o.src = src[2:0];  o.dst = dst[2:0];
        o.rwe = rwe;        o.maddr = maddr[2:0]; o.mbyte = mb;
        o.xwe = x;          o.ywe = y;          o.zwe = z;         o.ain = ain[1:0];
        o.op = op[9:0];     o.psw = psw;        o.mwe = mwe;       o.irwe = irwe;
        return o;
    endfunction

    function automatic out_t t0();
        return mk(0, 7, 7, 1, 0, 0, 0, 0, 0, 0, 13, 0, 0, 1);
    endfunction

    function automatic out_t idle(int cyc);
        return mk(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic add(input logic [15:0] c, input out_t e);
        vec_t v;
        v.cmd = c;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // ADD R1,R2
        add('o060102, t0()); add('o060102, idle(1)); add('o060102, idle(2));
        add('o060102, mk(3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // MOV @R1,R2
        add('o011102, t0());
        add('o011102, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add('o011102, idle(2));
        add('o011102, mk(3, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // CLRB @R3
        add('o105013, t0()); add('o105013, idle(1));
        add('o105013, mk(2, 0, 3, 0, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        add('o105013, mk(3, 0, 3, 0, 6, 1, 0, 0, 0, 2, 'h207, 1, 1, 0));
        // CMP R1,R2: no result write
        add('o020102, t0()); add('o020102, idle(1)); add('o020102, idle(2));
        add('o020102, mk(3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        // MOV (R1)+,R2: src mode 2 unsupported -> back to fetch after T1
        add('o012102, t0()); add('o012102, idle(1));
        // BICB @R4,@R5: both operands indirect, byte
        add('o141415, t0());
        add('o141415, mk(1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add('o141415, mk(2, 0, 5, 0, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        add('o141415, mk(3, 4, 5, 0, 6, 1, 0, 0, 0, 3, 'h205, 1, 1, 0));
        // SUB R1,R2: bit 15 set but word operation
        add('o160102, t0()); add('o160102, idle(1)); add('o160102, idle(2));
        add('o160102, mk(3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        // TST R0: no write
        add('o005700, t0()); add('o005700, idle(1)); add('o005700, idle(2));
        add('o005700, mk(3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0));
        // NEG R4
        add('o005404, t0()); add('o005404, idle(1)); add('o005404, idle(2));
        add('o005404, mk(3, 4, 4, 1, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0));
        // unsupported single opcode, then ADD with dst mode 2
        add('o005500, t0()); add('o005500, idle(1));
        add('o060122, t0()); add('o060122, idle(1));
        add('o060102, t0());

        reset = 1'b1;
        cmd   = 'o060102;
        @(negedge clk);
        #2;
        check("reset_state", act, mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            cmd = vecs[i].cmd;
            #1;
            check($sformatf("vec%0d_cmd%o", i, vecs[i].cmd), act, vecs[i].exp);
            step();
        end

        // Last vector was ADD at T0; now at T1. Advance to T2 and reset mid-instruction.
        step();
        #1;
        check("pre_reset_t2", act, idle(2));
        reset = 1'b1;
        #1;
        check("reset_mid_t2", act, mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0));
        step();
        check("reset_held", act, mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0));
        reset = 1'b0;
        #1;
        check("after_reset_t0", act, t0());

        // HALT: 0,1,7,7,7 with no enables after T0
        cmd = 16'd0;
        step();
        check("halt_t1", act, idle(1));
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("halt_t7_%0d", k), act, idle(7));
        end
        reset = 1'b1;
        #1;
        check("halt_reset", act, mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0));
        reset = 1'b0;
        #1;
        check("halt_exit_t0", act, t0());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
